dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/loader port.
- Grants at most one access per cycle.
- Stalls the pipeline while it loses arbitration.
- Routes one-cycle-latency read data back to the requester that issued the read.
- Sits between the MEM stage and the data memory; the data memory ports are driven only by this block.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MAX_WAIT, 4, number of consecutive lost DMA cycles before the DMA is given priority over the CPU. Legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request (MemRead|MemWrite).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  CPU request present but not granted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dma_req  in  1  DMA access request.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA access accepted this cycle.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  DATA_W  DMA read data.
- mem_read  out  1  to DataMemory MemRead.
- mem_write  out  1  to DataMemory MemWrite.
- mem_addr  out  ADDR_W  to DataMemory address.
- mem_wdata  out  DATA_W  to DataMemory writeData.
- mem_rdata  in  DATA_W  from DataMemory dataRead, valid the cycle after mem_read.

Behaviour:
- **Reset (reset_n low, asynchronous):**
  - rd_owner = IDLE, wait_cnt = 0.
  - mem_read, mem_write, dma_gnt, cpu_rvalid, dma_rvalid all forced to 0.
  - cpu_rdata, dma_rdata = 0; mem_addr, mem_wdata = 0.
  - cpu_stall = cpu_req.
- **Grant (combinational, same cycle as request):**
  - Only one requester active: it is granted.
  - Both active: CPU is granted unless wait_cnt == MAX_WAIT, in which case DMA is granted.
  - No request: nothing is granted; all mem_* outputs are 0.
- **Memory drive:** from the granted requester: mem_write = we, mem_read = ~we, plus its addr and wdata.
- **Stall/grant outputs:** cpu_stall = cpu_req & ~cpu_granted. dma_gnt = dma_granted.
- **Starvation counter wait_cnt (registered):**
  - Increments when dma_req & ~dma_granted, saturating at MAX_WAIT.
  - Cleared when dma_granted or when ~dma_req.
- **Read-return FSM rd_owner, states IDLE / RD_CPU / RD_DMA, updated every clock:**
  - Next state is RD_CPU if a CPU read was granted, RD_DMA if a DMA read was granted, else IDLE.
  - Any state can move to any state. Back-to-back reads are allowed with no bubble.
- **Read return (from the current rd_owner):**
  - cpu_rvalid = (rd_owner == RD_CPU); cpu_rdata = mem_rdata when RD_CPU, else 0.
  - dma_rvalid and dma_rdata behave the same way for RD_DMA.
  - Read latency is exactly 1 cycle after the grant.
- **Writes:** complete in the granted cycle and produce no rvalid.
- **Simultaneous events:**
  - A new grant in the same cycle as a read return is legal. The return is routed by the old rd_owner; the new read loads rd_owner.
  - A CPU write and a DMA write to the same address in the same cycle: only the winner is performed; the loser retries.
- **Reset mid-read:** the pending return is discarded and no rvalid follows reset release.
- **Requester contract:** a requester holds req/we/addr/wdata stable until granted (CPU: until cpu_stall falls). The arbiter does not check this.

Decomposition:
- Shared include arb_defs.vh holds:
  - rd_owner encodings: IDLE = 2'd0, RD_CPU = 2'd1, RD_DMA = 2'd2.
  - Default widths.
- One natural sub-module: arb_wait_counter (saturating counter with inc/clear inputs and a sat output), parameterised by MAX_WAIT.
- Grant logic and the rd_owner FSM stay in dmem_arbiter.

Test Plan:
- **CPU-only read:** cpu_req=1, cpu_we=0, cpu_addr=0x0010, memory[0x10]=0xBEEF → mem_read=1 same cycle; cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF, dma_rvalid=0.
- **Contention:** both requesting continuously, MAX_WAIT=4 → CPU granted 4 cycles with dma_gnt=0; 5th cycle dma_gnt=1, cpu_stall=1; wait_cnt returns to 0; CPU granted again on the 6th cycle.
- **Back-to-back reads:** CPU read 0x0002 in cycle N, DMA read 0x0003 in cycle N+1 → cycle N+1 cpu_rvalid=1 with data of 0x0002; cycle N+2 dma_rvalid=1 with data of 0x0003; no cross-routing.
- **DMA write then CPU read:** DMA write 0x0020 ← 0x1234 alone, then CPU read 0x0020 → mem_write=1 for one cycle, no rvalid; CPU then reads 0x1234.
- **Reset mid-read:** CPU read granted, reset_n low before the next edge → cpu_rvalid=0, all mem_* outputs 0; after release no spurious rvalid, wait_cnt=0.
- **DMA drops request while waiting:** DMA loses 3 cycles, deasserts dma_req, then reasserts → wait_cnt restarts from 0, so CPU keeps priority for 4 more contended cycles.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: read-return owner
// encodings and default widths.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;   // wide enough for MAX_WAIT up to 15

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DMA = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter; sat flags that the DMA has waited MAX_WAIT cycles.
module arb_wait_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 cnt <= '0;
        else if (clr)                 cnt <= '0;
        else if (inc && cnt != LIMIT) cnt <= cnt + 1'b1;
    end

    assign sat = (cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU has priority
// unless the DMA has starved for MAX_WAIT cycles; read data is routed back one cycle later.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic      sat;
    logic      cpu_granted, dma_granted;
    rd_owner_e rd_owner, rd_owner_n;

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (dma_req & ~dma_granted),
        .clr     (dma_granted | ~dma_req),
        .sat     (sat)
    );

    // Grants are gated by reset so nothing reaches memory while reset is held.
    always_comb begin
        cpu_granted = reset_n & cpu_req & (~dma_req | ~sat);
        dma_granted = reset_n & dma_req & ~cpu_granted;
        cpu_stall   = cpu_req & ~cpu_granted;
        dma_gnt     = dma_granted;
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_granted) begin
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_granted) begin
            mem_read  = ~dma_we;
            mem_write = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // rd_owner records who issued the read whose data arrives next cycle.
    always_comb begin
        rd_owner_n = IDLE;
        if (cpu_granted && !cpu_we)      rd_owner_n = RD_CPU;
        else if (dma_granted && !dma_we) rd_owner_n = RD_DMA;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_owner <= IDLE;
        else          rd_owner <= rd_owner_n;
    end

    always_comb begin
        cpu_rvalid = (rd_owner == RD_CPU);
        dma_rvalid = (rd_owner == RD_DMA);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dma_rdata  = dma_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a cycle-level
// reference model of the arbitration, starvation and read-return rules.
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Data memory attached to the DUT's memory port
    logic [DW-1:0] mem [0:255];
    always @(posedge clock) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:255];
    int            wc;
    int            pend;        // 0 none, 1 cpu, 2 dma
    logic [DW-1:0] pend_data;
    bit            last_cw, last_dw;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: called at posedge+1, checks mid-cycle, advances model at the edge.
    task automatic step();
        bit cw, dw;
        @(negedge clock);
        cw = cpu_req && (!dma_req || wc != MW);
        dw = dma_req && !cw;
        chk("cpu_stall", cpu_stall, cpu_req && !cw);
        chk("dma_gnt", dma_gnt, dw);
        chk("mem_read", mem_read, (cw && !cpu_we) || (dw && !dma_we));
        chk("mem_write", mem_write, (cw && cpu_we) || (dw && dma_we));
        chk("mem_addr", mem_addr, cw ? cpu_addr : dw ? dma_addr : '0);
        chk("mem_wdata", mem_wdata, cw ? cpu_wdata : dw ? dma_wdata : '0);
        chk("cpu_rvalid", cpu_rvalid, pend == 1);
        chk("cpu_rdata", cpu_rdata, pend == 1 ? pend_data : '0);
        chk("dma_rvalid", dma_rvalid, pend == 2);
        chk("dma_rdata", dma_rdata, pend == 2 ? pend_data : '0);
        pend = 0;
        if (cw && !cpu_we) begin pend = 1; pend_data = ref_mem[cpu_addr[7:0]]; end
        if (dw && !dma_we) begin pend = 2; pend_data = ref_mem[dma_addr[7:0]]; end
        if (cw && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
        if (dw && dma_we) ref_mem[dma_addr[7:0]] = dma_wdata;
        wc = (dma_req && !dw) ? ((wc < MW) ? wc + 1 : MW) : 0;
        last_cw = cw;
        last_dw = dw;
        @(posedge clock);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[16] = 16'hBEEF; ref_mem[16] = 16'hBEEF;
        wc = 0; pend = 0; pend_data = '0;

        // Reset state with a CPU request pending
        set_cpu(1'b1, 1'b0, 16'h0005, 16'h0);
        #2;
        chk("rst_cpu_stall", cpu_stall, 1'b1);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_dma_gnt", dma_gnt, 1'b0);
        chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        // CPU-only read of 0x0010
        set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
        step();
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        chk("cpu_rd_rvalid", cpu_rvalid, 1'b1);
        chk("cpu_rd_data", cpu_rdata, 16'hBEEF);
        chk("cpu_rd_dma_rvalid", dma_rvalid, 1'b0);
        step();

        // Contention: CPU wins MW cycles, then DMA once, then CPU again
        set_cpu(1'b1, 1'b0, 16'h0004, 16'h0);
        set_dma(1'b1, 1'b0, 16'h0005, 16'h0);
        for (int i = 0; i < MW + 2; i++) begin
            chk("cont_dma_gnt", dma_gnt, i == MW);
            chk("cont_cpu_stall", cpu_stall, i == MW);
            step();
            if (last_dw) set_dma(1'b0, 1'b0, 16'h0, 16'h0);
            if (last_dw) dma_req = 1'b1;   // DMA immediately issues another request
        end
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        step();

        // Back-to-back reads: CPU 0x0002 then DMA 0x0003
        set_cpu(1'b1, 1'b0, 16'h0002, 16'h0);
        step();
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        set_dma(1'b1, 1'b0, 16'h0003, 16'h0);
        chk("b2b_cpu_rvalid", cpu_rvalid, 1'b1);
        chk("b2b_cpu_data", cpu_rdata, ref_mem[2]);
        step();
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        chk("b2b_dma_rvalid", dma_rvalid, 1'b1);
        chk("b2b_cpu_rvalid2", cpu_rvalid, 1'b0);
        chk("b2b_dma_data", dma_rdata, ref_mem[3]);
        step();

        // DMA write 0x0020 <- 0x1234, then CPU read back
        set_dma(1'b1, 1'b1, 16'h0020, 16'h1234);
        step();
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        chk("wr_no_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
        set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
        step();
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        chk("wr_rd_data", cpu_rdata, 16'h1234);
        step();

        // Reset while a CPU read is outstanding
        set_cpu(1'b1, 1'b0, 16'h0007, 16'h0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mrst_mem_read", mem_read, 1'b0);
        chk("mrst_cpu_stall", cpu_stall, 1'b1);
        @(posedge clock); #1;
        chk("mrst_cpu_rvalid", cpu_rvalid, 1'b0);
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock); reset_n = 1'b1;
        wc = 0; pend = 0;
        @(posedge clock); #1;
        chk("mrst_after_rvalid", cpu_rvalid, 1'b0);
        step();

        // DMA loses 3 cycles, drops, reasserts: CPU keeps priority MW more cycles
        set_cpu(1'b1, 1'b0, 16'h0008, 16'h0);
        set_dma(1'b1, 1'b0, 16'h0009, 16'h0);
        for (int i = 0; i < 3; i++) step();
        dma_req = 1'b0;
        step();
        dma_req = 1'b1;
        for (int i = 0; i < MW + 1; i++) begin
            chk("drop_dma_gnt", dma_gnt, i == MW);
            step();
        end
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        step();

        // Random traffic; requests are held until granted
        for (int n = 0; n < 600; n++) begin
            if (!cpu_req || last_cw)
                set_cpu($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
            if (!dma_req || last_dw)
                set_dma($urandom_range(0, 2) != 0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
